// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU operation encoding and the control bundle
// that the ID stage hands to EX.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int ALU_CODE_W = 4;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'd5;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_dst;
    logic [ALU_CODE_W-1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/id_stage_hazard_reg_file.sv
// Register file: two combinational read ports with write-through from the
// single WB port; register 0 is hardwired to zero.
module reg_file #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : (wr_en && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/id_stage_hazard.sv
// MIPS decode stage: register read, control decode, immediate extension,
// branch/jump resolution in ID, hazard stall, and the ID/EX pipeline register.
module id_stage_hazard
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_id_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_plus_4_in,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_alu_result,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target,
  output logic [DATA_W-1:0]     read_data_1,
  output logic [DATA_W-1:0]     read_data_2,
  output logic [REG_ADDR_W-1:0] rs_ID,
  output logic [REG_ADDR_W-1:0] rt_ID,
  output logic [REG_ADDR_W-1:0] rd_ID,
  output logic [DATA_W-1:0]     imm_ext_ID,
  output logic [DATA_W-1:0]     pc_plus_4_out,
  output logic                  reg_write_ID,
  output logic                  mem_to_reg_ID,
  output logic                  mem_write_ID,
  output logic                  alu_src_ID,
  output logic                  reg_dst_ID,
  output logic [ALU_OP_W-1:0]   alu_op_ID,
  output logic                  valid_ID,
  output logic                  illegal_ID
);
  logic [5:0]            op, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [15:0]           imm16;
  logic [DATA_W-1:0]     rf_rs, rf_rt, cmp_a, cmp_b, imm_ext, jump_target;
  ctrl_t                 ctrl;
  logic                  illegal, is_beq, is_bne, is_j, is_br, reads_rt, zero_ext;
  logic                  load_use, br_ex_hz, br_mem_hz, issue;

  assign op    = instruction[31:26];
  assign funct = instruction[5:0];
  assign rs    = REG_ADDR_W'(instruction[25:21]);
  assign rt    = REG_ADDR_W'(instruction[20:16]);
  assign rd    = REG_ADDR_W'(instruction[15:11]);
  assign imm16 = instruction[15:0];

  reg_file #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_reg_write),
    .waddr (wb_rd),
    .wdata (wb_data),
    .raddr1(rs),
    .raddr2(rt),
    .rdata1(rf_rs),
    .rdata2(rf_rt)
  );

  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    reads_rt = 1'b0;
    zero_ext = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt       = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLL:  ctrl.alu_op = ALU_SLL;
          default: illegal     = 1'b1;
        endcase
      end
      OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_SLTI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_SLT; end
      OP_ANDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_AND; zero_ext = 1'b1; end
      OP_ORI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR;  zero_ext = 1'b1; end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin reads_rt = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_BEQ:  begin reads_rt = 1'b1; is_beq = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_BNE:  begin reads_rt = 1'b1; is_bne = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_J:    is_j = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  assign is_br   = is_beq | is_bne;
  assign imm_ext = zero_ext ? {{(DATA_W-16){1'b0}}, imm16} : {{(DATA_W-16){imm16[15]}}, imm16};

  // Branch operands only see MEM forwarding; anything younger forces a stall.
  assign cmp_a = (mem_reg_write && mem_rd != '0 && mem_rd == rs) ? mem_alu_result : rf_rs;
  assign cmp_b = (mem_reg_write && mem_rd != '0 && mem_rd == rt) ? mem_alu_result : rf_rt;

  assign load_use  = ex_mem_to_reg && ex_rd != '0 && (ex_rd == rs || (reads_rt && ex_rd == rt));
  assign br_ex_hz  = is_br && ex_reg_write && ex_rd != '0 && (ex_rd == rs || ex_rd == rt);
  assign br_mem_hz = is_br && mem_mem_to_reg && mem_rd != '0 && (mem_rd == rs || mem_rd == rt);
  assign stall     = if_id_valid && (load_use || br_ex_hz || br_mem_hz);

  assign branch_taken = if_id_valid && !stall &&
                        ((is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b) || is_j);

  always_comb begin
    jump_target                    = '0;
    jump_target[27:0]              = {instruction[25:0], 2'b00};
    jump_target[DATA_W-1:DATA_W-4] = pc_plus_4_in[DATA_W-1:DATA_W-4];
  end

  assign branch_target = is_j ? jump_target : pc_plus_4_in + (imm_ext << 2);

  // Taken control transfers have no EX work, so they retire here as bubbles.
  assign issue = if_id_valid && !stall && !illegal && !branch_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_1   <= '0;
      read_data_2   <= '0;
      rs_ID         <= '0;
      rt_ID         <= '0;
      rd_ID         <= '0;
      imm_ext_ID    <= '0;
      pc_plus_4_out <= '0;
      reg_write_ID  <= 1'b0;
      mem_to_reg_ID <= 1'b0;
      mem_write_ID  <= 1'b0;
      alu_src_ID    <= 1'b0;
      reg_dst_ID    <= 1'b0;
      alu_op_ID     <= '0;
      valid_ID      <= 1'b0;
      illegal_ID    <= 1'b0;
    end else begin
      read_data_1   <= rf_rs;
      read_data_2   <= rf_rt;
      rs_ID         <= rs;
      rt_ID         <= rt;
      rd_ID         <= rd;
      imm_ext_ID    <= imm_ext;
      pc_plus_4_out <= pc_plus_4_in;
      reg_write_ID  <= issue && ctrl.reg_write;
      mem_to_reg_ID <= issue && ctrl.mem_to_reg;
      mem_write_ID  <= issue && ctrl.mem_write;
      alu_src_ID    <= issue && ctrl.alu_src;
      reg_dst_ID    <= issue && ctrl.reg_dst;
      alu_op_ID     <= issue ? ALU_OP_W'(ctrl.alu_op) : '0;
      valid_ID      <= issue;
      illegal_ID    <= if_id_valid && !stall && illegal;
    end
  end
endmodule
